// File: rtl/serial_boot_pkg.sv
// Shared parser state encoding and frame constants for the serial boot loader.
// SERIAL_BOOT_CHECKSUM_EN adds the CSUM state to the enumeration.
package serial_boot_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
`ifdef SERIAL_BOOT_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_FINISH
  } state_t;

endpackage

// File: rtl/serial_boot_if.sv
// Byte-receive, bus-write and core-control signals of the serial boot loader.
// master = loader side, slave = environment side (UART front end, bus, core).
interface serial_boot_if;
  logic        rxnew;
  logic [7:0]  rxdata;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        ready;
  logic        cpu_rst;
  logic        done;
  logic        err;

  modport master (
    input  rxnew, rxdata, ready,
    output a, d, we, cpu_rst, done, err
  );

  modport slave (
    output rxnew, rxdata, ready,
    input  a, d, we, cpu_rst, done, err
  );
endinterface

// File: rtl/serial_boot_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push lands on the same edge.
// Push on full is refused unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/serial_boot.sv
// Serial boot loader: parses MAGIC/addr/len/data frames from a byte FIFO into bus writes;
// we rises one cycle after the last byte of a word, holds until ready. SERIAL_BOOT_CHECKSUM_EN adds a trailing XOR byte.
module serial_boot
  import serial_boot_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] MAGIC      = MAGIC_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  serial_boot_if.master bus
);
`ifdef SERIAL_BOOT_CHECKSUM_EN
  localparam state_t ST_AFTER = ST_CSUM;
  logic [7:0] csum;
`else
  localparam state_t ST_AFTER = ST_FINISH;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  fifo_dat;
  logic        fifo_full;
  logic        fifo_empty;
  logic        deq;
  logic        drop;
  logic [31:0] base;
  logic [31:0] len;
  logic [31:0] word;
  logic [31:0] idx;
  logic [1:0]  bcnt;
  logic        cpu_rst_q;
  logic        err_q;
  logic        last_byte;
  logic        last_word;
  logic [31:0] len_shift;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rxnew),
    .wdata (bus.rxdata),
    .pop   (deq),
    .rdata (fifo_dat),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign drop      = bus.rxnew && fifo_full && !deq;
  assign last_byte = (bcnt == 2'd3);
  assign len_shift = {len[23:0], fifo_dat};
  assign last_word = ((idx + 32'd1) == len);

  assign bus.a       = {base[31:2] + idx[29:0], 2'b00};
  assign bus.d       = word;
  assign bus.cpu_rst = cpu_rst_q;
  assign bus.err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deq       = 1'b0;
    bus.we    = 1'b0;
    bus.done  = 1'b0;
    case (state)
      ST_HUNT: begin
        deq = !fifo_empty;
        if (deq && fifo_dat == MAGIC) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        deq = !fifo_empty;
        if (deq && last_byte) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        deq = !fifo_empty;
        if (deq && last_byte) state_nxt = (len_shift == 32'd0) ? ST_AFTER : ST_DATA;
      end
      ST_DATA: begin
        deq = !fifo_empty;
        if (deq && last_byte) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        bus.we = 1'b1;
        if (bus.ready) state_nxt = last_word ? ST_AFTER : ST_DATA;
      end
`ifdef SERIAL_BOOT_CHECKSUM_EN
      ST_CSUM: begin
        deq = !fifo_empty;
        if (deq) state_nxt = (fifo_dat == csum) ? ST_FINISH : ST_HUNT;
      end
`endif
      ST_FINISH: begin
        bus.done  = 1'b1;
        state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      len       <= '0;
      word      <= '0;
      idx       <= '0;
      bcnt      <= '0;
      cpu_rst_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      if (deq) begin
        case (state)
          ST_HUNT: if (fifo_dat == MAGIC) begin
            bcnt      <= '0;
            idx       <= '0;
            cpu_rst_q <= 1'b1;
          end
          ST_ADDR: begin
            base <= {base[23:0], fifo_dat};
            bcnt <= bcnt + 2'd1;
          end
          ST_LEN: begin
            len  <= len_shift;
            bcnt <= bcnt + 2'd1;
          end
          ST_DATA: begin
            word <= {word[23:0], fifo_dat};
            bcnt <= bcnt + 2'd1;
          end
          default: ;
        endcase
      end
      if (state == ST_WRITE && bus.ready) idx <= idx + 32'd1;
      if (state == ST_FINISH) cpu_rst_q <= 1'b0;
      if (drop) err_q <= 1'b1;
`ifdef SERIAL_BOOT_CHECKSUM_EN
      if (state == ST_CSUM && deq && fifo_dat != csum) err_q <= 1'b1;
`endif
    end
  end

`ifdef SERIAL_BOOT_CHECKSUM_EN
  // Running XOR over every byte after MAGIC up to the checksum byte itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (deq) begin
      if (state == ST_HUNT && fifo_dat == MAGIC) csum <= '0;
      else if (state == ST_ADDR || state == ST_LEN || state == ST_DATA) csum <= csum ^ fifo_dat;
    end
  end
`endif
endmodule

// File: tb/tb_serial_boot.sv
// Bench for serial_boot: table of fixed frames, random frames against a frame-level model,
// and hand sequences for stall, overflow, mid-frame reset and (with SERIAL_BOOT_CHECKSUM_EN) bad checksum.
module tb_serial_boot;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] base;
    int          n;
    int          junk;
    int          rmode;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_writes;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_boot_if bus();

  serial_boot #(.FIFO_DEPTH(16), .MAGIC(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          ready_mode = 1;
  wr_t         got_q[$];
  int          done_seen = 0;
  logic [7:0]  fq[$];
  wr_t         exp_q[$];
  logic [31:0] wbuf [4];
  vec_t        vecs [5];

  // ready driver: 0 = low, 1 = high, otherwise random with ~75% high
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ready = 1'b0;
        1:       bus.ready = 1'b1;
        default: bus.ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.we && bus.ready) got_q.push_back({bus.a, bus.d});
      if (bus.done) done_seen++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_csum(input int start);
    logic [7:0] c = 8'h00;
    for (int k = start; k < fq.size(); k++) c = c ^ fq[k];
    return c;
  endfunction

  // Builds the byte stream and the expected write list straight from the frame fields.
  task automatic build(input logic [31:0] base, input int n, input int junk, input bit rand_junk);
    logic [7:0]  b;
    logic [31:0] n32;
    fq.delete();
    exp_q.delete();
    n32 = n;
    for (int j = 0; j < junk; j++) begin
      if (rand_junk) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
      end else begin
        b = (j % 2 == 1) ? 8'hFF : 8'h00;
      end
      fq.push_back(b);
    end
    fq.push_back(8'hA5);
    for (int k = 3; k >= 0; k--) fq.push_back(base[8*k +: 8]);
    for (int k = 3; k >= 0; k--) fq.push_back(n32[8*k +: 8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) fq.push_back(wbuf[i][8*k +: 8]);
      exp_q.push_back({(base & 32'hFFFF_FFFC) + 32'(4 * i), wbuf[i]});
    end
`ifdef SERIAL_BOOT_CHECKSUM_EN
    fq.push_back(frame_csum(junk + 1));
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rxnew  = 1'b1;
    bus.rxdata = b;
    @(posedge clk); #1;
    bus.rxnew = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a", bus.a, 32'h0);
    chk("rst_d", bus.d, 32'h0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input int settle);
    for (int c = 0; c < budget && done_seen == d0; c++) @(posedge clk);
    repeat (settle) @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input int budget);
    for (int c = 0; c < budget && bus.we !== 1'b1; c++) @(negedge clk);
  endtask

  task automatic cmp_writes(input string nm, input int w0);
    chk({nm, "_nwr"}, 32'(got_q.size() - w0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (w0 + i < got_q.size()) begin
        chk($sformatf("%s_a%0d", nm, i), got_q[w0 + i].a, exp_q[i].a);
        chk($sformatf("%s_d%0d", nm, i), got_q[w0 + i].d, exp_q[i].d);
      end
    end
  endtask

  task automatic run_frame(input string nm, input logic [31:0] base, input int n, input int junk,
                           input bit rj, input int rmode, input int gmin, input int gmax);
    int w0, d0;
    w0 = got_q.size();
    d0 = done_seen;
    ready_mode = rmode;
    build(base, n, junk, rj);
    for (int k = 0; k < fq.size(); k++) begin
      send_byte(fq[k], $urandom_range(gmin, gmax));
      if (k == junk + 4) chk({nm, "_cpu_rst_held"}, 32'(bus.cpu_rst), 32'd1);
    end
    wait_done(d0, 3000, 4);
    chk({nm, "_done"}, 32'(done_seen - d0), 32'd1);
    cmp_writes(nm, w0);
    chk({nm, "_err"}, 32'(bus.err), 32'd0);
    chk({nm, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd0);
  endtask

  initial begin
    int w0, d0, sent;
    bus.rxnew  = 1'b0;
    bus.rxdata = 8'h00;

    vecs[0] = '{32'h0000_0100, 2, 0, 1, 32'h1122_3344, 32'h5566_7788, 32'h0, 32'h0,
                32'h0000_0100, 32'h0000_0104, 2};
    vecs[1] = '{32'h0000_0000, 0, 2, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0};
    vecs[2] = '{32'hFFFF_FFF8, 3, 0, 1, 32'hA5A5_A5A5, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,
                32'hFFFF_FFF8, 32'h0000_0000, 3};
    vecs[3] = '{32'h0000_1003, 1, 1, 1, 32'h1357_9BDF, 32'h0, 32'h0, 32'h0,
                32'h0000_1000, 32'h0000_1000, 1};
    vecs[4] = '{32'h8000_0000, 4, 0, 2, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFEDC_BA98,
                32'h8000_0000, 32'h8000_000C, 4};

    do_reset();

    for (int v = 0; v < 5; v++) begin
      wbuf[0] = vecs[v].w0;
      wbuf[1] = vecs[v].w1;
      wbuf[2] = vecs[v].w2;
      wbuf[3] = vecs[v].w3;
      w0 = got_q.size();
      run_frame($sformatf("vec%0d", v), vecs[v].base, vecs[v].n, vecs[v].junk, 1'b0,
                vecs[v].rmode, 0, 2);
      chk($sformatf("vec%0d_count", v), 32'(got_q.size() - w0), 32'(vecs[v].exp_writes));
      if (vecs[v].exp_writes > 0 && got_q.size() >= w0 + vecs[v].exp_writes) begin
        chk($sformatf("vec%0d_first_a", v), got_q[w0].a, vecs[v].exp_first);
        chk($sformatf("vec%0d_last_a", v), got_q[w0 + vecs[v].exp_writes - 1].a, vecs[v].exp_last);
      end
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      run_frame($sformatf("rnd%0d", r), $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                1'b1, 2, 1, 2);
    end

    // ready held low for 10 cycles on the first write
    do_reset();
    ready_mode = 0;
    wbuf[0] = 32'hDEAD_BEEF;
    build(32'h0000_0200, 1, 0, 1'b0);
    w0 = got_q.size();
    d0 = done_seen;
    for (int k = 0; k < fq.size(); k++) send_byte(fq[k], 1);
    wait_we(200);
    chk("stall_we_rise", 32'(bus.we), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall_we_c%0d", c), 32'(bus.we), 32'd1);
      chk($sformatf("stall_a_c%0d", c), bus.a, 32'h0000_0200);
      chk($sformatf("stall_d_c%0d", c), bus.d, 32'hDEAD_BEEF);
    end
    chk("stall_no_early_wr", 32'(got_q.size() - w0), 32'd0);
    @(posedge clk); #1;
    ready_mode = 1;
    wait_done(d0, 500, 4);
    chk("stall_done", 32'(done_seen - d0), 32'd1);
    cmp_writes("stall", w0);

    // FIFO overflow while the parser is stuck in a write
    do_reset();
    ready_mode = 0;
    wbuf[0] = 32'hCAFE_F00D;
    wbuf[1] = 32'h0102_0304;
    build(32'h0000_0040, 2, 0, 1'b0);
    w0 = got_q.size();
    d0 = done_seen;
    for (int k = 0; k < 13; k++) send_byte(fq[k], 1);
    wait_we(200);
    chk("ovf_stalled", 32'(bus.we), 32'd1);
    @(posedge clk); #1;
    sent = 0;
    for (int k = 13; k < fq.size(); k++) begin
      send_byte(fq[k], 0);
      sent++;
    end
    while (sent < 16) begin
      send_byte(8'h00, 0);
      sent++;
    end
    chk("ovf_err_at_16", 32'(bus.err), 32'd0);
    send_byte(8'hA5, 0);
    chk("ovf_err_at_17", 32'(bus.err), 32'd1);
    ready_mode = 1;
    wait_done(d0, 500, 40);
    chk("ovf_done", 32'(done_seen - d0), 32'd1);
    cmp_writes("ovf", w0);
    chk("ovf_17th_lost", 32'(bus.cpu_rst), 32'd0);
    chk("ovf_err_sticky", 32'(bus.err), 32'd1);

    // reset after the 2nd data byte, then a complete new frame
    do_reset();
    ready_mode = 1;
    wbuf[0] = 32'h7777_8888;
    wbuf[1] = 32'h9999_AAAA;
    build(32'h0000_0300, 2, 0, 1'b0);
    for (int k = 0; k < 11; k++) send_byte(fq[k], 0);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    wbuf[0] = 32'h1111_2222;
    wbuf[1] = 32'h3333_4444;
    run_frame("midrst", 32'h0000_0500, 2, 0, 1'b0, 1, 0, 1);

`ifdef SERIAL_BOOT_CHECKSUM_EN
    do_reset();
    ready_mode = 1;
    wbuf[0] = 32'h0F0F_0F0F;
    build(32'h0000_0100, 1, 0, 1'b0);
    fq[fq.size() - 1] = fq[fq.size() - 1] ^ 8'h01;
    d0 = done_seen;
    for (int k = 0; k < fq.size(); k++) send_byte(fq[k], 0);
    repeat (30) @(posedge clk);
    #1;
    chk("csum_err", 32'(bus.err), 32'd1);
    chk("csum_no_done", 32'(done_seen - d0), 32'd0);
    chk("csum_cpu_rst", 32'(bus.cpu_rst), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
